// File: rtl/img_capture.sv
// Motion-vector capture: buffers block-matching results and logs them into a
// linear capture memory, closing every frame with a trailer word.
module img_capture #(
    parameter int          BLOCKS     = 396,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [21:0] ADDR_INIT  = 22'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mv_valid,
    input  logic [7:0]  mv_x,
    input  logic [7:0]  mv_y,
    input  logic [15:0] sad,
    output logic        mv_ready,
    output logic        wr_en,
    output logic [21:0] wr_addr,
    output logic [33:0] wr_data,
    input  logic        wr_ready,
    output logic        done,
    output logic        overflow
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] TRAILER = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // The registered write port is one of the FIFO_DEPTH buffer slots, so the queue holds one fewer.
    localparam int              QD       = FIFO_DEPTH - 1;
    localparam int              QW       = (QD > 1) ? $clog2(QD) : 1;
    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [QW-1:0]   QLAST    = QW'(QD - 1);
    localparam logic [CW-1:0]   QFULL    = CW'(QD);
    localparam logic [15:0]     BLK      = 16'(BLOCKS);
    localparam logic [21:0]     ADDR_MAX = 22'h3FFFFF;

    logic [1:0]    state;
    logic [15:0]   accepted;
    logic [15:0]   frame_cnt;
    logic          first_rec;
    logic [32:0]   q_mem [QD];
    logic [QW-1:0] rd_ptr;
    logic [QW-1:0] wr_ptr;
    logic [CW-1:0] q_cnt;

    logic        complete;
    logic        port_free;
    logic        q_empty;
    logic        accept;
    logic        pop;
    logic        bypass;
    logic        push;
    logic        take;
    logic        finish;
    logic        ovf_next;
    logic [32:0] rec_in;
    logic [32:0] take_rec;

    always_comb begin
        complete  = wr_en && wr_ready;
        port_free = !wr_en || wr_ready;
        q_empty   = (q_cnt == '0);
        mv_ready  = (state == CAPTURE) && !((q_cnt == QFULL) && wr_en) && (accepted < BLK);
        accept    = mv_valid && mv_ready;
        pop       = port_free && !q_empty;
        bypass    = port_free && q_empty && accept;
        push      = accept && !bypass;
        take      = pop || bypass;
        rec_in    = {first_rec, mv_x, mv_y, sad};
        take_rec  = pop ? q_mem[rd_ptr] : rec_in;
        ovf_next  = overflow || (complete && (wr_addr == ADDR_MAX));
        finish    = (state == CAPTURE) && (accepted == BLK) && q_empty && port_free;
        done      = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr] <= rec_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == QLAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == QLAST) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                q_cnt <= q_cnt + 1'b1;
            else if (pop && !push)
                q_cnt <= q_cnt - 1'b1;
        end
    end

    // Once overflowed, the trailer is consumed without a write, so TRAILER exits on the idle port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            accepted  <= '0;
            frame_cnt <= '0;
            first_rec <= 1'b0;
        end else begin
            if (accept) begin
                accepted  <= accepted + 16'd1;
                first_rec <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CAPTURE;
                        accepted  <= '0;
                        first_rec <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (finish)
                        state <= TRAILER;
                end
                TRAILER: begin
                    if (port_free) begin
                        state     <= DONE;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Records still drain from the queue after overflow; they are simply not presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= ADDR_INIT;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= ovf_next;
            if (complete) begin
                wr_en <= 1'b0;
                if (wr_addr != ADDR_MAX)
                    wr_addr <= wr_addr + 22'd1;
            end
            if (!ovf_next) begin
                if (take) begin
                    wr_en   <= 1'b1;
                    wr_data <= {take_rec[31:0], take_rec[32], 1'b1};
                end else if (finish) begin
                    wr_en   <= 1'b1;
                    wr_data <= {16'hE0F0, frame_cnt, 2'b00};
                end
            end
        end
    end

endmodule

// File: tb/tb_img_capture.sv
// Bench for img_capture: four instances (different BLOCKS / start address) share the
// engine-side stimulus; a frame table plus restart and mid-frame reset sequences.
module tb_img_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start_v;
    logic        mv_valid;
    logic        wr_ready;
    logic [7:0]  mv_x;
    logic [7:0]  mv_y;
    logic [15:0] sad;
    logic [3:0]  rdy_v;
    logic [3:0]  en_v;
    logic [3:0]  done_v;
    logic [3:0]  ovf_v;
    logic [21:0] addr_v [4];
    logic [33:0] data_v [4];

    logic [1:0]  sel = 2'd0;
    logic        c_rdy;
    logic        c_en;
    logic        c_done;
    logic        c_ovf;
    logic [21:0] c_addr;
    logic [33:0] c_data;

    int checks = 0;
    int errors = 0;

    logic [55:0] obs_q [$];
    logic [55:0] exp_q [$];
    int          done_cnt = 0;
    int          unstable_cnt = 0;
    logic        hold_prev = 1'b0;
    logic [55:0] prev_word;

    logic [21:0] addr_model [4];
    logic [15:0] fcnt_model [4];
    logic        ovf_model [4];
    logic        first_model;
    int          rec_idx = 0;
    int          done0;
    int          unst0;

    typedef struct {
        int          inst;
        int          nrec;
        int          stall_s;
        int          stall_n;
        logic [21:0] first_addr;
        logic [21:0] end_addr;
        logic        ovf;
        int          stall_acc;
        int          cycles;
    } frame_t;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        img_capture #(
            .BLOCKS    (g == 1 ? 8 : (g == 3 ? 2 : 3)),
            .FIFO_DEPTH(4),
            .ADDR_INIT (g == 2 ? 22'h3FFFFE : 22'h0)
        ) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start_v[g]),
            .mv_valid(mv_valid),
            .mv_x    (mv_x),
            .mv_y    (mv_y),
            .sad     (sad),
            .mv_ready(rdy_v[g]),
            .wr_en   (en_v[g]),
            .wr_addr (addr_v[g]),
            .wr_data (data_v[g]),
            .wr_ready(wr_ready),
            .done    (done_v[g]),
            .overflow(ovf_v[g])
        );
    end

    assign c_rdy  = rdy_v[sel];
    assign c_en   = en_v[sel];
    assign c_done = done_v[sel];
    assign c_ovf  = ovf_v[sel];
    assign c_addr = addr_v[sel];
    assign c_data = data_v[sel];

    // Observes the selected instance mid-cycle: completed writes, done cycles, held-word stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (c_en && wr_ready)
                obs_q.push_back({c_addr, c_data});
            if (c_done)
                done_cnt++;
            if (hold_prev && (!c_en || ({c_addr, c_data} != prev_word)))
                unstable_cnt++;
            hold_prev = c_en && !wr_ready;
            prev_word = {c_addr, c_data};
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] rec_word(input int k);
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] s;
        x = 8'(k + 1);
        y = 8'(-(k + 1));
        s = 16'((k + 1) * 16);
        return {x, y, s};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [33:0] d);
        if (!ovf_model[sel]) begin
            exp_q.push_back({addr_model[sel], d});
            if (addr_model[sel] == 22'h3FFFFF)
                ovf_model[sel] = 1'b1;
            else
                addr_model[sel] = addr_model[sel] + 22'd1;
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < 4; i++) begin
            addr_model[i] = (i == 2) ? 22'h3FFFFE : 22'h0;
            fcnt_model[i] = 16'h0;
            ovf_model[i]  = 1'b0;
        end
    endtask

    task automatic start_frame(input int inst);
        sel = 2'(inst);
        obs_q.delete();
        exp_q.delete();
        done0 = done_cnt;
        unst0 = unstable_cnt;
        start_v[sel] = 1'b1;
        tick();
        start_v = '0;
        first_model = 1'b1;
    endtask

    // Engine model: holds each record until accepted; wr_ready low inside the stall window.
    task automatic apply_stimulus(input int n, input int s0, input int sn,
                                  output int cycles, output int acc_rel);
        int   k;
        int   cyc;
        logic got;
        k = 0;
        cyc = 0;
        acc_rel = -1;
        while (k < n && cyc < 300) begin
            {mv_x, mv_y, sad} = rec_word(rec_idx);
            mv_valid = 1'b1;
            wr_ready = !(cyc >= s0 && cyc < s0 + sn);
            @(negedge clk);
            got = c_rdy;
            if (got) begin
                push_expected({rec_word(rec_idx), first_model, 1'b1});
                first_model = 1'b0;
                rec_idx++;
                k++;
            end
            tick();
            cyc++;
            if (got && k == 1)
                check_output("latency_wr_en", c_en, 1);
            if (sn > 0 && cyc == s0 + sn)
                acc_rel = k;
        end
        mv_valid = 1'b0;
        cycles = cyc;
        if (k < n)
            check_output("feed_timeout", k, n);
    endtask

    task automatic finish_frame(input logic [21:0] first_addr);
        logic [55:0] e;
        logic [55:0] o;
        push_expected({16'hE0F0, fcnt_model[sel], 2'b00});
        fcnt_model[sel] = fcnt_model[sel] + 16'd1;
        mv_valid = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 300 && done_cnt == done0; i++)
            tick();
        repeat (3) tick();
        check_output("first_addr", (obs_q.size() > 0) ? obs_q[0][55:34] : ~first_addr, first_addr);
        check_output("done_pulses", done_cnt - done0, 1);
        check_output("hold_stable", unstable_cnt - unst0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                check_output("write_word", o, e);
            end else begin
                check_output("write_missing", obs_q.size(), exp_q.size() + 1);
            end
        end
        check_output("extra_writes", obs_q.size(), 0);
    endtask

    initial begin
        frame_t tbl [6];
        int     cyc;
        int     acc_rel;

        tbl[0] = '{0, 3, 0,  0, 22'h000000, 22'h000004, 1'b0, -1, 3};
        tbl[1] = '{0, 3, 1,  3, 22'h000004, 22'h000008, 1'b0, -1, -1};
        tbl[2] = '{3, 2, 0,  0, 22'h000000, 22'h000003, 1'b0, -1, 2};
        tbl[3] = '{3, 2, 0,  0, 22'h000003, 22'h000006, 1'b0, -1, 2};
        tbl[4] = '{1, 8, 0, 10, 22'h000000, 22'h000009, 1'b0, 4, -1};
        tbl[5] = '{2, 3, 0,  0, 22'h3FFFFE, 22'h3FFFFF, 1'b1, -1, 3};

        rst_n    = 1'b0;
        start_v  = '0;
        mv_valid = 1'b0;
        wr_ready = 1'b1;
        mv_x     = '0;
        mv_y     = '0;
        sad      = '0;
        reset_models();

        #12;
        check_output("rst_mv_ready", c_rdy, 0);
        check_output("rst_wr_en", c_en, 0);
        check_output("rst_wr_addr", c_addr, 0);
        check_output("rst_wr_data", c_data, 0);
        check_output("rst_done", c_done, 0);
        check_output("rst_overflow", c_ovf, 0);
        rst_n = 1'b1;
        repeat (4) tick();
        check_output("idle_mv_ready", c_rdy, 0);
        check_output("idle_wr_en", c_en, 0);

        for (int f = 0; f < 6; f++) begin
            start_frame(tbl[f].inst);
            apply_stimulus(tbl[f].nrec, tbl[f].stall_s, tbl[f].stall_n, cyc, acc_rel);
            if (tbl[f].cycles >= 0)
                check_output("throughput_cycles", cyc, tbl[f].cycles);
            if (tbl[f].stall_acc >= 0)
                check_output("stall_accepts", acc_rel, tbl[f].stall_acc);
            finish_frame(tbl[f].first_addr);
            check_output("end_addr", c_addr, tbl[f].end_addr);
            check_output("overflow_flag", c_ovf, tbl[f].ovf);
        end

        // A second start in the middle of a frame must not restart the count or the first flag.
        start_frame(0);
        apply_stimulus(1, 0, 0, cyc, acc_rel);
        start_v[0] = 1'b1;
        tick();
        start_v = '0;
        apply_stimulus(2, 0, 0, cyc, acc_rel);
        finish_frame(22'h000008);
        check_output("restart_end_addr", c_addr, 22'h00000C);

        // Reset with one record held at a stalled write port.
        start_frame(0);
        apply_stimulus(1, 0, 1000, cyc, acc_rel);
        check_output("pre_reset_wr_en", c_en, 1);
        rst_n = 1'b0;
        #2;
        check_output("midrst_mv_ready", c_rdy, 0);
        check_output("midrst_wr_en", c_en, 0);
        check_output("midrst_wr_addr", c_addr, 0);
        check_output("midrst_wr_data", c_data, 0);
        check_output("midrst_done", c_done, 0);
        check_output("midrst_overflow", c_ovf, 0);
        tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        obs_q.delete();
        exp_q.delete();
        reset_models();
        repeat (5) tick();
        check_output("post_rst_wr_en", c_en, 0);
        check_output("post_rst_writes", obs_q.size(), 0);
        check_output("post_rst_mv_ready", c_rdy, 0);
        start_frame(0);
        apply_stimulus(3, 0, 0, cyc, acc_rel);
        finish_frame(22'h000000);
        check_output("post_rst_end_addr", c_addr, 22'h000004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
